// File: rtl/pll_sup_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_sup_pkg : state codes and one-hot indices for pll_lock_supervisor |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pll_sup_pkg;

  localparam logic [1:0] RESET_PLL = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABILIZE = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET_PLL = RESET_PLL,
    ST_WAIT_LOCK = WAIT_LOCK,
    ST_STABILIZE = STABILIZE,
    ST_RUN       = RUN
  } pll_state_e;

  localparam int NUM_STATES    = 4;
  localparam int IDX_RESET_PLL = 0;
  localparam int IDX_WAIT_LOCK = 1;
  localparam int IDX_STABILIZE = 2;
  localparam int IDX_RUN       = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_sync2 : 2-flop synchronizer, async active-high reset to 0         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pll_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_lock_supervisor : drives PLL reset, qualifies lock, flags ready   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int STABLE_CYCLES = 4096,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] relock_cnt,
  output logic             timeout_err
);

  localparam int CTR_MAX = max3(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CTR_W   = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;
  localparam logic [CTR_W-1:0] RST_LAST  = CTR_W'(RST_PULSE - 1);
  localparam logic [CTR_W-1:0] TMO_LAST  = CTR_W'(LOCK_TIMEOUT - 1);
  localparam logic [CTR_W-1:0] STAB_LAST = CTR_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_STATES-1:0] ONEHOT_RESET = NUM_STATES'(1) << IDX_RESET_PLL;

  logic                  locked_s;
  logic [NUM_STATES-1:0] onehot_q, onehot_d;
  logic [CTR_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      relock_q, relock_d;
  logic                  timeout_q, timeout_d;
  pll_state_e            cur_st, nxt_st;

  pll_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk     (refclk),
    .rst     (rst),
    .async_i (locked),
    .sync_o  (locked_s)
  );

  always_comb begin
    cur_st = ST_RESET_PLL;
    if (onehot_q[IDX_WAIT_LOCK]) cur_st = ST_WAIT_LOCK;
    if (onehot_q[IDX_STABILIZE]) cur_st = ST_STABILIZE;
    if (onehot_q[IDX_RUN])       cur_st = ST_RUN;
  end

  // Lock beats timeout in WAIT_LOCK; loss beats terminal count in STABILIZE.
  always_comb begin
    nxt_st    = cur_st;
    timeout_d = 1'b0;
    relock_d  = relock_q;
    case (cur_st)
      ST_RESET_PLL: if (cnt_q == RST_LAST) nxt_st = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          nxt_st = ST_STABILIZE;
        end else if (cnt_q == TMO_LAST) begin
          nxt_st    = ST_RESET_PLL;
          timeout_d = 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s)               nxt_st = ST_WAIT_LOCK;
        else if (cnt_q == STAB_LAST) nxt_st = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          nxt_st = ST_RESET_PLL;
          if (relock_q != '1) relock_d = relock_q + CNT_W'(1);
        end
      end
      default: nxt_st = ST_RESET_PLL;
    endcase
    onehot_d         = '0;
    onehot_d[nxt_st] = 1'b1;
    cnt_d            = (nxt_st != cur_st) ? '0 : cnt_q + CTR_W'(1);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      onehot_q  <= ONEHOT_RESET;
      cnt_q     <= '0;
      relock_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      onehot_q  <= onehot_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      timeout_q <= timeout_d;
    end
  end

  assign pll_rst     = onehot_q[IDX_RESET_PLL];
  assign ready       = onehot_q[IDX_RUN];
  assign state       = cur_st;
  assign relock_cnt  = relock_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_lock_supervisor : directed bench with a phase/elapsed model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pll_lock_supervisor;

  localparam int RST_PULSE     = 4;
  localparam int LOCK_TIMEOUT  = 64;
  localparam int STABLE_CYCLES = 16;
  localparam int CNT_W         = 2;
  localparam int CNT_SAT       = (1 << CNT_W) - 1;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             locked = 1'b1;
  logic             pll_rst, ready, timeout_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] relock_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_PULSE     (RST_PULSE),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk      (clk),
    .rst         (rst),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .ready       (ready),
    .state       (state),
    .relock_cnt  (relock_cnt),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Model: phase number, cycles elapsed in phase, locked seen two samples late.
  int m_phase  = 0;
  int m_age    = 0;
  int m_relock = 0;
  bit m_tmo    = 1'b0;
  bit m_d1     = 1'b0;
  bit m_d2     = 1'b0;

  initial begin : model
    int prev;
    bit seen;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_age = 0; m_relock = 0; m_tmo = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
      end else begin
        seen  = m_d2;
        m_d2  = m_d1;
        m_d1  = locked;
        prev  = m_phase;
        m_tmo = 1'b0;
        if (prev == 0 && m_age + 1 >= RST_PULSE) m_phase = 1;
        else if (prev == 1 && seen) m_phase = 2;
        else if (prev == 1 && m_age + 1 >= LOCK_TIMEOUT) begin m_phase = 0; m_tmo = 1'b1; end
        else if (prev == 2 && !seen) m_phase = 1;
        else if (prev == 2 && m_age + 1 >= STABLE_CYCLES) m_phase = 3;
        else if (prev == 3 && !seen) begin
          m_phase  = 0;
          m_relock = (m_relock + 1 > CNT_SAT) ? CNT_SAT : m_relock + 1;
        end
        m_age = (m_phase == prev) ? m_age + 1 : 0;
      end
    end
  end

  initial begin : compare
    int exp_v, got_v;
    forever begin
      @(negedge clk);
      #1;
      exp_v = {(m_phase == 0), (m_phase == 3), m_phase[1:0], m_relock[CNT_W-1:0], m_tmo};
      got_v = {pll_rst, ready, state, relock_cnt, timeout_err};
      check("cycle_outputs", got_v, exp_v);
    end
  end

  task automatic reset_dut(input bit lk);
    rst    = 1'b1;
    locked = lk;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drop_lock(input int n_after);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    repeat (n_after - 1) @(negedge clk);
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_relock"}, relock_cnt, 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  initial begin : stimulus
    int n_hi, first_rdy, first_tmo, last_tmo, n_tmo, rdy_seen, st16, st21;
    int exp_relock[5] = '{1, 2, 3, 3, 3};

    repeat (2) @(negedge clk);

    // Cold start with lock already present
    rst = 1'b0;
    n_hi = 0; first_rdy = -1;
    for (int k = 0; k < 40; k++) begin
      if (pll_rst) n_hi++;
      if (ready && first_rdy < 0) first_rdy = k;
      @(negedge clk);
    end
    check("cold_pll_rst_cycles", n_hi, 4);
    check("cold_ready_cycle", first_rdy, 21);
    check("cold_state", state, 3);
    check("cold_relock", relock_cnt, 0);

    // PLL never locks
    reset_dut(1'b0);
    n_hi = 0; first_tmo = -1; last_tmo = -1; n_tmo = 0; rdy_seen = 0;
    for (int k = 0; k < 210; k++) begin
      if (pll_rst) n_hi++;
      if (ready) rdy_seen = 1;
      if (timeout_err) begin
        if (first_tmo < 0) first_tmo = k;
        last_tmo = k;
        n_tmo++;
      end
      @(negedge clk);
    end
    check("nolock_first_tmo", first_tmo, 68);
    check("nolock_last_tmo", last_tmo, 204);
    check("nolock_tmo_count", n_tmo, 3);
    check("nolock_pll_rst_cycles", n_hi, 16);
    check("nolock_ready_seen", rdy_seen, 0);

    // Glitch while stabilizing
    reset_dut(1'b1);
    first_rdy = -1; n_tmo = 0; st16 = -1; st21 = -1;
    for (int k = 0; k < 51; k++) begin
      if (k == 16) st16 = state;
      if (k == 21) st21 = state;
      if (ready && first_rdy < 0) first_rdy = k;
      if (timeout_err) n_tmo++;
      if (k == 13) locked = 1'b0;
      if (k == 18) locked = 1'b1;
      @(negedge clk);
    end
    check("glitch_state_back", st16, 1);
    check("glitch_state_restab", st21, 2);
    check("glitch_ready_cycle", first_rdy, 37);
    check("glitch_tmo_count", n_tmo, 0);
    check("glitch_relock", relock_cnt, 0);

    // Five losses in RUN, counter saturates
    for (int i = 0; i < 5; i++) begin
      n_hi = 0;
      locked = 1'b0;
      for (int m = 1; m <= 30; m++) begin
        @(negedge clk);
        if (m == 1) locked = 1'b1;
        if (pll_rst) n_hi++;
        if (m == 2)  check("loss_ready_m2", ready, 1);
        if (m == 3)  check("loss_ready_m3", ready, 0);
        if (m == 23) check("loss_ready_m23", ready, 0);
        if (m == 24) check("loss_ready_m24", ready, 1);
      end
      check("loss_pll_rst_cycles", n_hi, 4);
      check("loss_relock", relock_cnt, exp_relock[i]);
    end

    // Async reset mid-STABILIZE with relock_cnt=2
    reset_dut(1'b1);
    repeat (21) @(negedge clk);
    check("rst6_ready_run", ready, 1);
    drop_lock(30);
    drop_lock(12);
    check("rst6_pre_stab_state", state, 2);
    check("rst6_pre_stab_relock", relock_cnt, 2);
    #2 rst = 1'b1;
    #1 check_reset_now("rst_mid_stab");
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-RUN with relock_cnt=2
    repeat (21) @(negedge clk);
    drop_lock(30);
    drop_lock(30);
    check("rst6_pre_run_state", state, 3);
    check("rst6_pre_run_relock", relock_cnt, 2);
    #2 rst = 1'b1;
    #1 check_reset_now("rst_mid_run");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
